// File: rtl/sprite_dma_arb_pkg.sv
// sprite_dma_arb_pkg
//   Shared definitions for the sprite copy engine and its port arbiter:
//   DMA register offsets relative to REG_BASE, the CTRL start bit, and the
//   engine state encoding.
package sprite_dma_arb_pkg;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dma_state_e;

endpackage

// File: rtl/sprite_dma_arb_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO holding read data returned to the copy engine.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset (empties the FIFO)
//     push, wdata write one entry
//     pop         drop the head entry (caller only pops when not empty)
//     rdata       current head entry (combinational)
//     count       number of valid entries, 0..DEPTH
//     empty       count == 0
//   Push and pop in the same cycle is allowed and leaves count unchanged.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_idx_q;
    logic [AW-1:0]    rd_idx_q;
    logic [AW:0]      count_q;

    // DEPTH is a power of two, so the index counters wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_idx_q <= wr_idx_q + 1'b1;
            if (pop)  rd_idx_q <= rd_idx_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_idx_q] <= wdata;
    end

    assign rdata = mem_q[rd_idx_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/sprite_dma_arb.sv
// sprite_dma_arb
//   Copy engine plus port arbiter between the CPU and the unified memory
//   block. The CPU programs SRC/DST/LEN at REG_BASE+0..2 and writes CTRL
//   (REG_BASE+3) with the start bit set; the engine then moves LEN words
//   from SRC to DST using read and write cycles the CPU leaves idle.
//   Ports:
//     clk, rst_n                      clock, asynchronous active-low reset
//     cpu_ren, cpu_raddr              CPU read request
//     cpu_wen, cpu_waddr, cpu_wdata   CPU write request (always passed on)
//     mem_ren, mem_raddr              read port to memory (combinational mux)
//     mem_wen, mem_waddr, mem_wdata   write port to memory (combinational mux)
//     mem_rdata                       read data, valid READ_LAT cycles later
//     dma_busy                        copy in progress
//     dma_done                        one-cycle pulse with the final write
//   The CPU always wins both ports. FIFO_DEPTH must be a power of two and
//   at least READ_LAT+1.
module sprite_dma_arb
    import sprite_dma_arb_pkg::*;
#(
    parameter int          READ_LAT   = 2,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] REG_BASE   = 16'hffd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_ren,
    input  logic [15:0] cpu_raddr,
    input  logic        cpu_wen,
    input  logic [15:0] cpu_waddr,
    input  logic [15:0] cpu_wdata,
    output logic        mem_ren,
    output logic [15:0] mem_raddr,
    output logic        mem_wen,
    output logic [15:0] mem_waddr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        dma_busy,
    output logic        dma_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    dma_state_e state_q, state_d;

    logic [15:0] src_q, dst_q, len_q;
    logic [15:0] rd_ptr_q, wr_ptr_q, rd_left_q, wr_left_q;
    logic [READ_LAT-1:0] tag_q;
    logic done_zero_q;

    logic [15:0]      reg_off_full;
    logic             reg_hit;
    logic             start_req;
    logic             dma_rd, dma_wr, last_wr;
    logic [CNT_W:0]   inflight;
    logic             credit_ok;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic [15:0]      fifo_head;

    // Register decode; the write itself still reaches memory.
    assign reg_off_full = cpu_waddr - REG_BASE;
    assign reg_hit      = cpu_wen && (reg_off_full < 16'd4);
    assign start_req    = reg_hit && (reg_off_full[1:0] == REG_CTRL)
                          && cpu_wdata[CTRL_START];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
        end else if (reg_hit) begin
            case (reg_off_full[1:0])
                REG_SRC: src_q <= cpu_wdata;
                REG_DST: dst_q <= cpu_wdata;
                REG_LEN: len_q <= cpu_wdata;
                default: ;
            endcase
        end
    end

    // Credit: every outstanding DMA read already owns a FIFO slot, so a
    // return can always be pushed without overflow.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + {{CNT_W{1'b0}}, tag_q[i]};
        end
    end

    assign credit_ok = ({1'b0, fifo_count} + inflight) < (CNT_W+1)'(FIFO_DEPTH);
    assign dma_rd    = (state_q == RUN) && !cpu_ren && (rd_left_q != '0) && credit_ok;
    assign dma_wr    = (state_q == RUN) && !cpu_wen && !fifo_empty;
    assign last_wr   = dma_wr && (wr_left_q == 16'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_req && (len_q != '0)) state_d = RUN;
            RUN:  if (last_wr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            rd_left_q   <= '0;
            wr_left_q   <= '0;
            done_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            // A zero-length start completes without leaving IDLE.
            done_zero_q <= (state_q == IDLE) && start_req && (len_q == '0);
            if ((state_q == IDLE) && start_req && (len_q != '0)) begin
                rd_ptr_q  <= src_q;
                wr_ptr_q  <= dst_q;
                rd_left_q <= len_q;
                wr_left_q <= len_q;
            end else begin
                if (dma_rd) begin
                    rd_ptr_q  <= rd_ptr_q + 16'd1;
                    rd_left_q <= rd_left_q - 16'd1;
                end
                if (dma_wr) begin
                    wr_ptr_q  <= wr_ptr_q + 16'd1;
                    wr_left_q <= wr_left_q - 16'd1;
                end
            end
        end
    end

    // Tag pipeline mirrors the memory read latency; a tag leaving the last
    // stage marks mem_rdata as a DMA return. CPU returns carry no tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= dma_rd;
            for (int i = 1; i < READ_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tag_q[READ_LAT-1]),
        .wdata (mem_rdata),
        .pop   (dma_wr),
        .rdata (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign mem_ren   = cpu_ren || dma_rd;
    assign mem_raddr = dma_rd ? rd_ptr_q : cpu_raddr;
    assign mem_wen   = cpu_wen || dma_wr;
    assign mem_waddr = dma_wr ? wr_ptr_q : cpu_waddr;
    assign mem_wdata = dma_wr ? fifo_head : cpu_wdata;

    assign dma_busy = (state_q == RUN);
    assign dma_done = done_zero_q || last_wr;

endmodule

// File: tb/tb_sprite_dma_arb.sv
// tb_sprite_dma_arb
//   Directed bench for sprite_dma_arb with a READ_LAT=2 memory model whose
//   contents are a fixed function of the address.
module tb_sprite_dma_arb;

    localparam logic [15:0] REG_BASE = 16'hffd0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_ren;
    logic [15:0] cpu_raddr;
    logic        cpu_wen;
    logic [15:0] cpu_waddr;
    logic [15:0] cpu_wdata;
    logic        mem_ren;
    logic [15:0] mem_raddr;
    logic        mem_wen;
    logic [15:0] mem_waddr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        dma_busy;
    logic        dma_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Observation queues filled by the monitor
    logic [15:0] wr_a_q[$];
    logic [15:0] wr_d_q[$];
    int          wr_c_q[$];
    logic [15:0] rd_a_q[$];
    int          rd_c_q[$];
    int          done_c_q[$];
    int          busy_cnt;
    int          first_busy;
    logic [15:0] exp_q[$];

    sprite_dma_arb #(
        .READ_LAT   (2),
        .FIFO_DEPTH (4),
        .REG_BASE   (REG_BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_ren   (cpu_ren),
        .cpu_raddr (cpu_raddr),
        .cpu_wen   (cpu_wen),
        .cpu_waddr (cpu_waddr),
        .cpu_wdata (cpu_wdata),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dma_busy  (dma_busy),
        .dma_done  (dma_done)
    );

    // ---------------- clock / reset / memory model ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5a5a;
    endfunction

    logic        req_v = 1'b0;
    logic [15:0] req_a = 16'h0;
    logic [15:0] rd_pipe = 16'h0;

    always @(negedge clk) begin
        req_v = mem_ren;
        req_a = mem_raddr;
    end

    always @(posedge clk) begin
        rd_pipe   <= req_v ? mem_f(req_a) : 16'h0;
        mem_rdata <= rd_pipe;
    end

    // Monitor: DMA-owned port cycles are those where the CPU is not asking.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wen && !cpu_wen) begin
                wr_a_q.push_back(mem_waddr);
                wr_d_q.push_back(mem_wdata);
                wr_c_q.push_back(cyc);
            end
            if (mem_ren && !cpu_ren) begin
                rd_a_q.push_back(mem_raddr);
                rd_c_q.push_back(cyc);
            end
            if (dma_done) done_c_q.push_back(cyc);
            if (dma_busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 ns after a rising edge.
    task automatic clear_mon();
        wr_a_q.delete(); wr_d_q.delete(); wr_c_q.delete();
        rd_a_q.delete(); rd_c_q.delete(); done_c_q.delete();
        exp_q.delete();
        busy_cnt   = 0;
        first_busy = -1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        cpu_wen   = 1'b1;
        cpu_waddr = a;
        cpu_wdata = d;
        @(posedge clk); #1;
        cpu_wen   = 1'b0;
    endtask

    task automatic program_regs(input logic [15:0] src, input logic [15:0] dst,
                                input logic [15:0] len);
        cpu_write(REG_BASE + 16'd0, src);
        cpu_write(REG_BASE + 16'd1, dst);
        cpu_write(REG_BASE + 16'd2, len);
    endtask

    task automatic wait_writes(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (wr_a_q.size() < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (wr_a_q.size() < n) begin
            failures++;
            $display("FAIL %s_timeout writes=%0d required=%0d", tag, wr_a_q.size(), n);
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; cpu_ren = 1'b0; cpu_wen = 1'b0;
        cpu_raddr = 16'h1234; cpu_waddr = 16'h4321; cpu_wdata = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_ren !== 1'b0) begin failures++; $display("FAIL rst_mem_ren got=%b exp=0", mem_ren); end
        checks++; if (mem_raddr !== 16'h1234) begin failures++; $display("FAIL rst_mem_raddr got=%h exp=1234", mem_raddr); end
        checks++; if (mem_wen !== 1'b0) begin failures++; $display("FAIL rst_mem_wen got=%b exp=0", mem_wen); end
        checks++; if (mem_waddr !== 16'h4321) begin failures++; $display("FAIL rst_mem_waddr got=%h exp=4321", mem_waddr); end
        checks++; if (dma_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", dma_busy); end
        checks++; if (dma_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", dma_done); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // Register writes and CPU reads pass straight through
        cpu_wen = 1'b1; cpu_waddr = REG_BASE; cpu_wdata = 16'h0100;
        cpu_ren = 1'b1; cpu_raddr = 16'h0055;
        @(negedge clk);
        checks++; if (mem_wen !== 1'b1 || mem_waddr !== REG_BASE || mem_wdata !== 16'h0100) begin
            failures++; $display("FAIL reg_passthru got=%b/%h/%h exp=1/%h/0100", mem_wen, mem_waddr, mem_wdata, REG_BASE);
        end
        checks++; if (mem_ren !== 1'b1 || mem_raddr !== 16'h0055) begin
            failures++; $display("FAIL rd_passthru got=%b/%h exp=1/0055", mem_ren, mem_raddr);
        end
        @(posedge clk); #1;
        cpu_wen = 1'b0; cpu_ren = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_basic_copy();
        int s;
        clear_mon();
        program_regs(16'h0100, 16'ha000, 16'd4);
        s = cyc;
        cpu_write(REG_BASE + 16'd3, 16'h0001);
        wait_writes(4, 40, "basic");
        for (int i = 0; i < 4; i++) exp_q.push_back(mem_f(16'h0100 + 16'(i)));
        checks++; if (wr_a_q.size() !== 4) begin failures++; $display("FAIL basic_nwr got=%0d exp=4", wr_a_q.size()); end
        for (int i = 0; i < 4 && i < wr_a_q.size(); i++) begin
            checks++;
            if (wr_a_q[i] !== 16'ha000 + 16'(i) || wr_d_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL basic_wr%0d got=%h:%h exp=%h:%h", i, wr_a_q[i], wr_d_q[i], 16'ha000 + 16'(i), exp_q[i]);
            end
        end
        checks++; if (wr_c_q.size() > 0 && wr_c_q[0] !== s + 4) begin failures++; $display("FAIL basic_first_wr_cyc got=%0d exp=%0d", wr_c_q[0], s + 4); end
        checks++; if (done_c_q.size() !== 1) begin failures++; $display("FAIL basic_ndone got=%0d exp=1", done_c_q.size()); end
        checks++; if (done_c_q.size() > 0 && done_c_q[0] !== s + 7) begin failures++; $display("FAIL basic_done_cyc got=%0d exp=%0d", done_c_q[0], s + 7); end
        checks++; if (first_busy !== s + 1) begin failures++; $display("FAIL basic_busy_start got=%0d exp=%0d", first_busy, s + 1); end
        checks++; if (busy_cnt !== 7) begin failures++; $display("FAIL basic_busy_len got=%0d exp=7", busy_cnt); end
    endtask

    task automatic test_cpu_contention();
        int s;
        clear_mon();
        program_regs(16'h0100, 16'ha000, 16'd4);
        s = cyc;
        cpu_write(REG_BASE + 16'd3, 16'h0001);
        for (int k = 0; k < 8; k++) begin
            cpu_ren   = (k < 6);
            cpu_raddr = 16'h0300 + 16'(k);
            @(negedge clk);
            if (k < 6) begin
                checks++;
                if (mem_ren !== 1'b1 || mem_raddr !== 16'h0300 + 16'(k)) begin
                    failures++;
                    $display("FAIL cont_cpu_rd%0d got=%b/%h exp=1/%h", k, mem_ren, mem_raddr, 16'h0300 + 16'(k));
                end
            end
            if (k >= 2) begin
                checks++;
                if (mem_rdata !== mem_f(16'h0300 + 16'(k - 2))) begin
                    failures++;
                    $display("FAIL cont_cpu_data%0d got=%h exp=%h", k - 2, mem_rdata, mem_f(16'h0300 + 16'(k - 2)));
                end
            end
            @(posedge clk); #1;
        end
        cpu_ren = 1'b0;
        wait_writes(4, 40, "cont");
        checks++; if (rd_c_q.size() > 0 && rd_c_q[0] !== s + 7) begin failures++; $display("FAIL cont_first_dma_rd got=%0d exp=%0d", rd_c_q[0], s + 7); end
        for (int i = 0; i < 4 && i < wr_a_q.size(); i++) begin
            checks++;
            if (wr_a_q[i] !== 16'ha000 + 16'(i) || wr_d_q[i] !== mem_f(16'h0100 + 16'(i))) begin
                failures++;
                $display("FAIL cont_wr%0d got=%h:%h exp=%h:%h", i, wr_a_q[i], wr_d_q[i], 16'ha000 + 16'(i), mem_f(16'h0100 + 16'(i)));
            end
        end
        checks++; if (done_c_q.size() !== 1 || done_c_q[0] !== s + 13) begin failures++; $display("FAIL cont_done got=%0d pulses exp=1 at %0d", done_c_q.size(), s + 13); end
    endtask

    task automatic test_write_collision();
        int s;
        clear_mon();
        program_regs(16'h0100, 16'ha000, 16'd4);
        s = cyc;
        cpu_write(REG_BASE + 16'd3, 16'h0001);
        repeat (3) begin @(posedge clk); #1; end
        // Cycle s+4: the first DMA write is pending; the CPU takes the port
        cpu_wen = 1'b1; cpu_waddr = 16'h0200; cpu_wdata = 16'hbeef;
        @(negedge clk);
        checks++;
        if (mem_wen !== 1'b1 || mem_waddr !== 16'h0200 || mem_wdata !== 16'hbeef) begin
            failures++; $display("FAIL coll_cpu_wr got=%b/%h/%h exp=1/0200/beef", mem_wen, mem_waddr, mem_wdata);
        end
        @(posedge clk); #1;
        cpu_wen = 1'b0;
        wait_writes(4, 40, "coll");
        checks++; if (wr_c_q.size() > 0 && wr_c_q[0] !== s + 5) begin failures++; $display("FAIL coll_first_dma_wr got=%0d exp=%0d", wr_c_q[0], s + 5); end
        checks++; if (wr_a_q.size() !== 4) begin failures++; $display("FAIL coll_nwr got=%0d exp=4", wr_a_q.size()); end
        for (int i = 0; i < 4 && i < wr_a_q.size(); i++) begin
            checks++;
            if (wr_a_q[i] !== 16'ha000 + 16'(i) || wr_d_q[i] !== mem_f(16'h0100 + 16'(i))) begin
                failures++;
                $display("FAIL coll_wr%0d got=%h:%h exp=%h:%h", i, wr_a_q[i], wr_d_q[i], 16'ha000 + 16'(i), mem_f(16'h0100 + 16'(i)));
            end
        end
        checks++; if (done_c_q.size() !== 1 || done_c_q[0] !== s + 8) begin failures++; $display("FAIL coll_done got=%0d pulses exp=1 at %0d", done_c_q.size(), s + 8); end
    endtask

    task automatic test_len_zero();
        int s;
        clear_mon();
        program_regs(16'h0100, 16'ha000, 16'd0);
        s = cyc;
        cpu_write(REG_BASE + 16'd3, 16'h0001);
        repeat (5) begin @(posedge clk); #1; end
        checks++; if (done_c_q.size() !== 1) begin failures++; $display("FAIL len0_ndone got=%0d exp=1", done_c_q.size()); end
        checks++; if (done_c_q.size() > 0 && done_c_q[0] !== s + 1) begin failures++; $display("FAIL len0_done_cyc got=%0d exp=%0d", done_c_q[0], s + 1); end
        checks++; if (wr_a_q.size() !== 0) begin failures++; $display("FAIL len0_nwr got=%0d exp=0", wr_a_q.size()); end
        checks++; if (busy_cnt !== 0) begin failures++; $display("FAIL len0_busy got=%0d exp=0", busy_cnt); end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_ra[3];
        logic [15:0] exp_wa[3];
        clear_mon();
        exp_ra = '{16'hfffe, 16'hffff, 16'h0000};
        exp_wa = '{16'hffff, 16'h0000, 16'h0001};
        for (int i = 0; i < 3; i++) exp_q.push_back(mem_f(exp_ra[i]));
        program_regs(16'hfffe, 16'hffff, 16'd3);
        cpu_write(REG_BASE + 16'd3, 16'h0001);
        wait_writes(3, 40, "wrap");
        checks++; if (rd_a_q.size() !== 3) begin failures++; $display("FAIL wrap_nrd got=%0d exp=3", rd_a_q.size()); end
        for (int i = 0; i < 3 && i < rd_a_q.size(); i++) begin
            checks++; if (rd_a_q[i] !== exp_ra[i]) begin failures++; $display("FAIL wrap_rd%0d got=%h exp=%h", i, rd_a_q[i], exp_ra[i]); end
        end
        for (int i = 0; i < 3 && i < wr_a_q.size(); i++) begin
            checks++;
            if (wr_a_q[i] !== exp_wa[i] || wr_d_q[i] !== exp_q[i]) begin
                failures++; $display("FAIL wrap_wr%0d got=%h:%h exp=%h:%h", i, wr_a_q[i], wr_d_q[i], exp_wa[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_copy();
        int k;
        clear_mon();
        program_regs(16'h0400, 16'ha100, 16'd8);
        cpu_write(REG_BASE + 16'd3, 16'h0001);
        k = 0;
        while (wr_a_q.size() < 2 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        checks++; if (wr_a_q.size() !== 2) begin failures++; $display("FAIL rmid_pre_writes got=%0d exp=2", wr_a_q.size()); end
        rst_n = 1'b0;
        #1;
        checks++; if (dma_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", dma_busy); end
        checks++; if (dma_done !== 1'b0) begin failures++; $display("FAIL rmid_done got=%b exp=0", dma_done); end
        checks++; if (dut.fifo_count !== '0) begin failures++; $display("FAIL rmid_fifo got=%0d exp=0", dut.fifo_count); end
        checks++; if (mem_wen !== 1'b0) begin failures++; $display("FAIL rmid_wen got=%b exp=0", mem_wen); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        checks++; if (wr_a_q.size() !== 2) begin failures++; $display("FAIL rmid_post_writes got=%0d exp=2", wr_a_q.size()); end
        checks++; if (done_c_q.size() !== 0) begin failures++; $display("FAIL rmid_ndone got=%0d exp=0", done_c_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_copy();
        test_cpu_contention();
        test_write_collision();
        test_len_zero();
        test_wrap();
        test_reset_mid_copy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
